// File: rtl/wb_regfile.sv
// wb_regfile: write-back end of the MEM/WB interface.
//
// Selects the write-back result (load data or ALU output), commits it into a
// 2**ADDR_W entry register file with register 0 hardwired to zero, serves two
// combinational ID read ports with same-cycle write-to-read bypass, and exposes
// a non-bypassed debug read port plus a committed-write counter.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous active-high reset (clears registers and counter)
//   RegWriteW  write-back enable
//   MemtoRegW  result select: 1 = ReadDataW, 0 = ALUOutW
//   ReadDataW  load data
//   ALUOutW    ALU result
//   WriteRegW  destination register index
//   RA1D/RA2D  ID read addresses
//   RD1D/RD2D  ID read data (bypassed)
//   ResultW    selected write-back value, combinational
//   DbgAddr    debug read address
//   DbgData    debug read data, committed state only
//   WbCount    committed writes since reset, wraps modulo 2**CNT_W
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteW,
    input  logic              MemtoRegW,
    input  logic [DATA_W-1:0] ReadDataW,
    input  logic [DATA_W-1:0] ALUOutW,
    input  logic [ADDR_W-1:0] WriteRegW,
    input  logic [ADDR_W-1:0] RA1D,
    input  logic [ADDR_W-1:0] RA2D,
    output logic [DATA_W-1:0] RD1D,
    output logic [DATA_W-1:0] RD2D,
    output logic [DATA_W-1:0] ResultW,
    input  logic [ADDR_W-1:0] DbgAddr,
    output logic [DATA_W-1:0] DbgData,
    output logic [CNT_W-1:0]  WbCount
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [CNT_W-1:0]  wb_count;
    logic              commit;

    assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;

    // A write commits only outside reset and never to register 0; the same
    // qualifier gates the read bypass so reads of $0 and reads during reset
    // never see the in-flight result.
    assign commit = !rst && RegWriteW && (WriteRegW != '0);

    // Read with bypass: the in-flight result wins over the array so a
    // same-cycle write and read of one register returns the new value.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic              bypass_en,
        input logic [ADDR_W-1:0] wr_addr,
        input logic [DATA_W-1:0] wr_data,
        input logic [DATA_W-1:0] arr_data
    );
        if (addr == '0)
            return '0;
        else if (bypass_en && (wr_addr == addr))
            return wr_data;
        else
            return arr_data;
    endfunction

    assign RD1D = read_port(RA1D, commit, WriteRegW, ResultW, regs[RA1D]);
    assign RD2D = read_port(RA2D, commit, WriteRegW, ResultW, regs[RA2D]);

    // Debug port shows committed contents only; $0 forced for robustness.
    assign DbgData = (DbgAddr == '0) ? '0 : regs[DbgAddr];
    assign WbCount = wb_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            wb_count <= '0;
        end else if (commit) begin
            regs[WriteRegW] <= ResultW;
            wb_count        <= wb_count + CNT_W'(1);
        end
    end

endmodule
